cam_pipelined_ternary: RTL and testbench

Parametrised, register-based ternary CAM that succeeds the fixed-configuration binary CAM wrapper in the lookup datapath. It adds per-entry valid bits, per-entry stored masks, per-lookup compare masks, single-entry invalidate, a sequenced full-table flush, and a fully pipelined lookup with fixed 2-cycle latency and multiple-match reporting. It sits between the table-programming register interface and the header-parser lookup path of an output-port or forwarding stage.

---
 rtl/cam_pipelined_ternary_pkg.sv | 12 +
 rtl/cam_prio_enc.sv | 20 ++
 rtl/cam_pipelined_ternary.sv | 108 ++++++++++
 tb/tb_cam_pipelined_ternary.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cam_pipelined_ternary_pkg.sv
// cam_pipelined_ternary_pkg: shared types, sizing and helpers for the ternary CAM.
package cam_pipelined_ternary_pkg;
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_e;
  localparam int CAM_ADDR_WIDTH = 4;
  localparam int CAM_DEPTH = 2 ** CAM_ADDR_WIDTH;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/cam_prio_enc.sv
// cam_prio_enc: lowest-index priority encoder with any/multiple flags.
module cam_prio_enc
  import cam_pipelined_ternary_pkg::*;
#(
  parameter int N = CAM_DEPTH,
  parameter int W = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic         any,
  output logic [W-1:0] index,
  output logic         multiple
);
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) index = vec[i] ? W'(i) : index;
  end
  assign any      = |vec;
  // clearing the lowest set bit leaves something only if two or more were set
  assign multiple = |(vec & (vec - N'(1)));
endmodule

// File: rtl/cam_pipelined_ternary.sv
// cam_pipelined_ternary: register-based ternary CAM with flush sweep and a
// two-stage lookup pipeline (hit vector, then priority encode).
module cam_pipelined_ternary
  import cam_pipelined_ternary_pkg::*;
#(
  parameter int C_ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int C_DATA_WIDTH = 16,
  parameter int C_TERNARY    = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WE,
  input  logic                    WR_VALID,
  input  logic [C_ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [C_DATA_WIDTH-1:0] DIN,
  input  logic [C_DATA_WIDTH-1:0] DATA_MASK,
  input  logic                    FLUSH,
  output logic                    BUSY,
  input  logic                    CMP_REQ,
  input  logic [C_DATA_WIDTH-1:0] CMP_DIN,
  input  logic [C_DATA_WIDTH-1:0] CMP_DATA_MASK,
  output logic                    MATCH_VALID,
  output logic                    MATCH,
  output logic [C_ADDR_WIDTH-1:0] MATCH_ADDR,
  output logic                    MULTIPLE_MATCH
);
  localparam int DEPTH = 2 ** C_ADDR_WIDTH;
  localparam logic [C_ADDR_WIDTH-1:0] LAST = C_ADDR_WIDTH'(DEPTH - 1);
  logic [C_DATA_WIDTH-1:0] key_q [DEPTH];
  logic [C_DATA_WIDTH-1:0] key_d [DEPTH];
  logic [C_DATA_WIDTH-1:0] mask_q [DEPTH];
  logic [C_DATA_WIDTH-1:0] mask_d [DEPTH];
  logic [C_DATA_WIDTH-1:0] cmp_mask;
  logic [DEPTH-1:0]        valid_q, valid_d, hit_q, hit_d;
  state_e                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d, enc_idx;
  logic                    req_q, req_d, mv_q, mv_d, match_q, match_d, multi_q, multi_d;
  logic                    enc_any, enc_multi, wr_en;
  assign wr_en    = WE && state_q == IDLE;
  assign cmp_mask = (C_TERNARY != 0) ? CMP_DATA_MASK : '0;
  always_comb begin
    key_d   = key_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    state_d = state_q;
    ptr_d   = ptr_q;
    if (wr_en) begin
      valid_d[WR_ADDR] = WR_VALID;
      key_d[WR_ADDR]   = WR_VALID ? DIN : key_q[WR_ADDR];
      mask_d[WR_ADDR]  = WR_VALID ? ((C_TERNARY != 0) ? DATA_MASK : '0) : mask_q[WR_ADDR];
    end
    // a write accepted with FLUSH in the same cycle is wiped by the sweep that follows
    if (state_q == SWEEP) begin
      valid_d[ptr_q] = 1'b0;
      ptr_d          = (ptr_q == LAST) ? '0 : ptr_q + C_ADDR_WIDTH'(1);
      state_d        = (ptr_q == LAST) ? IDLE : SWEEP;
    end else if (FLUSH) begin
      state_d = SWEEP;
    end
  end
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < DEPTH; i++)
      hit_d[i] = valid_q[i] && ~|((key_q[i] ^ CMP_DIN) & ~(mask_q[i] | cmp_mask));
  end
  cam_prio_enc #(.N(DEPTH), .W(C_ADDR_WIDTH)) u_enc (
    .vec(hit_q), .any(enc_any), .index(enc_idx), .multiple(enc_multi)
  );
  always_comb begin
    req_d   = CMP_REQ;
    mv_d    = req_q;
    match_d = req_q && enc_any;
    addr_d  = (req_q && enc_any) ? enc_idx : '0;
    multi_d = req_q && enc_multi;
  end
  always_ff @(posedge CLK) begin
    key_q  <= key_d;
    mask_q <= mask_d;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      state_q <= IDLE;
      ptr_q   <= '0;
      req_q   <= 1'b0;
      hit_q   <= '0;
      mv_q    <= 1'b0;
      match_q <= 1'b0;
      addr_q  <= '0;
      multi_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      hit_q   <= hit_d;
      mv_q    <= mv_d;
      match_q <= match_d;
      addr_q  <= addr_d;
      multi_q <= multi_d;
    end
  end
  assign BUSY           = state_q == SWEEP;
  assign MATCH_VALID    = mv_q;
  assign MATCH          = match_q;
  assign MATCH_ADDR     = addr_q;
  assign MULTIPLE_MATCH = multi_q;
endmodule

// File: tb/tb_cam_pipelined_ternary.sv
// tb_cam_pipelined_ternary: directed plus random stimulus against a table-level
// reference model of the ternary CAM.
module tb_cam_pipelined_ternary;
  localparam int D = 16;
  localparam int TERN = 1;
  typedef struct {
    logic       v;
    logic       m;
    logic       mm;
    logic [3:0] a;
  } res_t;
  logic        clk = 0, rst = 1, we = 0, wr_valid = 0, flush = 0, cmp_req = 0;
  logic [3:0]  wr_addr = 0;
  logic [15:0] din = 0, dmask = 0, cdin = 0, cmask = 0;
  logic        busy, mv, m, mm;
  logic [3:0]  maddr;
  logic [15:0] rk [D];
  logic [15:0] rm [D];
  bit          rv [D];
  int          sweep_left = 0, rptr = 0, nvec = 0, nerr = 0, n;
  res_t        p1 = '{default: 0}, o = '{default: 0};

  cam_pipelined_ternary #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(16), .C_TERNARY(TERN)) dut (
    .CLK(clk), .RST(rst), .WE(we), .WR_VALID(wr_valid), .WR_ADDR(wr_addr), .DIN(din),
    .DATA_MASK(dmask), .FLUSH(flush), .BUSY(busy), .CMP_REQ(cmp_req), .CMP_DIN(cdin),
    .CMP_DATA_MASK(cmask), .MATCH_VALID(mv), .MATCH(m), .MATCH_ADDR(maddr),
    .MULTIPLE_MATCH(mm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t lookup(input logic req, input logic [15:0] k, input logic [15:0] cm);
    res_t r;
    int   hits;
    r = '{default: 0};
    hits = 0;
    for (int i = 0; i < D; i++)
      if (rv[i] && (((rk[i] ^ k) & ~(rm[i] | (TERN != 0 ? cm : 16'h0))) == 16'h0)) begin
        if (hits == 0) r.a = 4'(i);
        hits++;
      end
    r.v  = req;
    r.m  = req && hits > 0;
    r.mm = req && hits > 1;
    if (!req) r.a = 0;
    return r;
  endfunction

  task automatic cycle();
    res_t nx;
    nx = lookup(cmp_req, cdin, cmask);
    @(posedge clk);
    #1;
    if (sweep_left > 0) begin
      rv[rptr] = 0;
      rptr++;
      sweep_left--;
    end else begin
      if (we) begin
        rv[wr_addr] = wr_valid;
        if (wr_valid) begin
          rk[wr_addr] = din;
          rm[wr_addr] = TERN != 0 ? dmask : 16'h0;
        end
      end
      if (flush) begin
        sweep_left = D;
        rptr = 0;
      end
    end
    o  = p1;
    p1 = nx;
    we = 0;
    flush = 0;
    cmp_req = 0;
    chk("busy", busy, sweep_left > 0);
    chk("match_valid", mv, o.v);
    chk("match", m, o.m);
    chk("match_addr", maddr, o.a);
    chk("multiple", mm, o.mm);
  endtask

  task automatic do_reset();
    rst = 1;
    #2;
    for (int i = 0; i < D; i++) rv[i] = 0;
    sweep_left = 0;
    rptr = 0;
    p1 = '{default: 0};
    chk("rst_busy", busy, 0);
    chk("rst_match_valid", mv, 0);
    #1 rst = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] k, input logic [15:0] mk);
    we = 1; wr_valid = 1; wr_addr = a; din = k; dmask = mk;
    cycle();
  endtask

  task automatic inval(input logic [3:0] a);
    we = 1; wr_valid = 0; wr_addr = a;
    cycle();
  endtask

  task automatic look(input logic [15:0] k, input logic [15:0] mk);
    cmp_req = 1; cdin = k; cmask = mk;
    cycle();
  endtask

  initial begin
    do_reset();
    look(16'h0000, 16'h0);
    cycle();
    chk("empty_mv", mv, 1);
    chk("empty_match", m, 0);
    chk("empty_addr", maddr, 0);
    wr(3, 16'h1234, 16'h0);
    look(16'h1234, 16'h0);
    cycle();
    chk("e3_match", m, 1);
    chk("e3_addr", maddr, 3);
    chk("e3_multi", mm, 0);
    we = 1; wr_valid = 1; wr_addr = 7; din = 16'h5555; dmask = 0;
    cmp_req = 1; cdin = 16'h5555; cmask = 0;
    cycle();
    cycle();
    chk("same_cycle_miss", m, 0);
    wr(5, 16'hAB00, 16'h00FF);
    wr(9, 16'hABCD, 16'h0);
    look(16'hABCD, 16'h0);
    cycle();
    chk("tern_addr", maddr, 5);
    chk("tern_multi", mm, 1);
    inval(5);
    look(16'hABCD, 16'h0);
    cycle();
    chk("inval_addr", maddr, 9);
    chk("inval_multi", mm, 0);
    wr(2, 16'h00F0, 16'h0);
    look(16'h00FF, 16'h000F);
    cycle();
    chk("cmpmask_match", m, 1);
    chk("cmpmask_addr", maddr, 2);
    for (int i = 0; i < D; i++) wr(4'(i), 16'h1000 + 16'(i), 16'h0);
    flush = 1;
    cycle();
    n = 0;
    while (busy && n < 40) begin
      if (n == 1) begin we = 1; wr_valid = 1; wr_addr = 0; din = 16'h7777; dmask = 0; end
      if (n == 8) begin cmp_req = 1; cdin = 16'h1000; cmask = 0; end
      if (n == 9) begin cmp_req = 1; cdin = 16'h100F; cmask = 0; end
      cycle();
      if (n == 9) chk("sweep_k0_miss", m, 0);
      if (n == 10) chk("sweep_k15_hit", m, 1);
      n++;
    end
    chk("busy_len", n, 16);
    look(16'h7777, 16'h0);
    cycle();
    chk("busy_we_dropped", m, 0);
    we = 1; wr_valid = 1; wr_addr = 4; din = 16'h4444; dmask = 0; flush = 1;
    cycle();
    n = 0;
    while (busy && n < 40) begin cycle(); n++; end
    chk("we_flush_len", n, 16);
    look(16'h4444, 16'h0);
    cycle();
    chk("we_flush_empty", m, 0);
    wr(1, 16'hBEEF, 16'h0);
    wr(6, 16'hCAFE, 16'h0);
    flush = 1;
    cycle();
    cycle();
    look(16'hCAFE, 16'h0);
    look(16'hBEEF, 16'h0);
    do_reset();
    cycle();
    look(16'hCAFE, 16'h0);
    look(16'hBEEF, 16'h0);
    cycle();
    chk("post_rst_miss", m, 0);
    repeat (600) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      we       = $urandom_range(0, 2) == 0;
      wr_valid = $urandom_range(0, 3) != 0;
      wr_addr  = 4'($urandom_range(0, 15));
      din      = 16'($urandom_range(0, 15)) * 16'h0101;
      dmask    = $urandom_range(0, 3) == 0 ? 16'h0003 : 16'h0;
      flush    = $urandom_range(0, 59) == 0;
      cmp_req  = $urandom_range(0, 1) == 1;
      cdin     = 16'($urandom_range(0, 15)) * 16'h0101;
      cmask    = $urandom_range(0, 3) == 0 ? 16'h0101 : 16'h0;
      cycle();
    end
    cycle();
    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
